// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one read port and one write port
// between instruction fetch and load/store, with data priority and a streak limit.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic [31:0] mem_rd_addr_o,
  input  logic [31:0] mem_rd_data_i,
  output logic [31:0] mem_wr_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic        mem_wr_enable_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_t;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] MAXS = 4'(MAX_STREAK);

  state_t      state_q, state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        if_rv_q, if_rv_d;
  logic        d_rv_q, d_rv_d;
  logic        if_gnt, d_gnt;

  // Grant decision: only in IDLE, data wins unless fetch has starved long enough
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (state_q == IDLE) begin
      if_gnt = if_req_i && (!d_req_i || (streak_q == MAXS));
      d_gnt  = d_req_i && !if_gnt;
    end
  end

  // Next-state logic for the access sequencer, streak counter and data paths
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    streak_d  = streak_q;
    if_rv_d   = 1'b0;
    d_rv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_gnt) begin
          rd_addr_d = if_addr_i;
          owner_d   = 1'b0;
          cnt_d     = LAT;
          streak_d  = 4'd0;
          state_d   = RD_WAIT;
        end else if (d_gnt) begin
          if (if_req_i && (streak_q != MAXS)) begin
            streak_d = streak_q + 4'd1;
          end
          if (d_we_i) begin
            wr_addr_d = d_addr_i;
            wr_data_d = d_wdata_i;
            state_d   = WR;
          end else begin
            rd_addr_d = d_addr_i;
            owner_d   = 1'b1;
            cnt_d     = LAT;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d = mem_rd_data_i;
          if_rv_d = !owner_q;
          d_rv_d  = owner_q;
          state_d = IDLE;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any access in progress
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      streak_q  <= '0;
      if_rv_q   <= 1'b0;
      d_rv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      if_rv_q   <= if_rv_d;
      d_rv_q    <= d_rv_d;
    end
  end

  assign if_gnt_o        = if_gnt;
  assign d_gnt_o         = d_gnt;
  assign if_rvalid_o     = if_rv_q;
  assign d_rvalid_o      = d_rv_q;
  assign if_rdata_o      = rdata_q;
  assign d_rdata_o       = rdata_q;
  assign mem_rd_addr_o   = rd_addr_q;
  assign mem_wr_addr_o   = wr_addr_q;
  assign mem_wr_data_o   = wr_data_q;
  assign mem_wr_enable_o = (state_q == WR);
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Memory data is valid only in the single cycle the arbiter should sample it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
  logic        mem_wr_en, busy;

  int          cyc = 0;
  int          data_cyc = -1;
  logic [31:0] data_val = '0;
  int          total = 0;
  int          bad = 0;

  logic        s_req;
  logic [31:0] s_addr;
  logic [1:0]  s_gnt, s_rv;
  logic [1:0][31:0] s_rdata;
  int          s_dcyc[2] = '{-1, -1};
  logic [31:0] s_dval[2] = '{32'h0, 32'h0};
  int          s_lat[2] = '{0, 7};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rd_data = (cyc == data_cyc) ? data_val : 32'hBADBAD00;

  mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata),
    .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
    .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
    .mem_wr_enable_o(mem_wr_en), .busy_o(busy)
  );

  for (genvar k = 0; k < 2; k++) begin : g_sw
    localparam int unsigned L = (k == 0) ? 0 : 7;
    logic        dg, drv, we, bz;
    logic [31:0] drd, ra, wa, wd, mrd;
    assign mrd = (cyc == s_dcyc[k]) ? s_dval[k] : 32'hBADBAD00;
    mem_port_arbiter #(.MEM_LAT(L), .MAX_STREAK(4)) u (
      .clk_i(clk), .reset_i(reset_i),
      .if_req_i(s_req), .if_addr_i(s_addr), .if_gnt_o(s_gnt[k]),
      .if_rvalid_o(s_rv[k]), .if_rdata_o(s_rdata[k]),
      .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(32'h0),
      .d_wdata_i(32'h0), .d_gnt_o(dg), .d_rvalid_o(drv),
      .d_rdata_o(drd),
      .mem_rd_addr_o(ra), .mem_rd_data_i(mrd),
      .mem_wr_addr_o(wa), .mem_wr_data_o(wd),
      .mem_wr_enable_o(we), .busy_o(bz)
    );
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] o;
    repeat (2) nxt();
    #1;
    o = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wr_en, busy} | if_rdata
      | mem_rd_addr | mem_wr_addr | mem_wr_data | d_rdata;
    total++; if (o !== 32'h0) begin bad++; $display("FAIL reset_in: got %h want 0", o); end
    nxt(); reset_i = 1'b0; #1;
    o = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wr_en, busy} | if_rdata
      | mem_rd_addr | mem_wr_addr | mem_wr_data | d_rdata;
    total++; if (o !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want 0", o); end
  endtask

  task automatic test_fetch_only();
    int g;
    nxt(); if_req = 1'b1; if_addr = 32'h100; #1;
    g = cyc; data_cyc = g + 2; data_val = 32'hDEADBEEF;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL f_gnt: got %b want 1", if_gnt); end
    total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL f_dgnt: got %b want 0", d_gnt); end
    nxt(); if_req = 1'b0; if_addr = 32'h0; #1;
    total++; if (mem_rd_addr !== 32'h100) begin bad++; $display("FAIL f_addr1: got %h want 100", mem_rd_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL f_busy: got %b want 1", busy); end
    nxt(); #1;
    total++; if (mem_rd_addr !== 32'h100) begin bad++; $display("FAIL f_addr2: got %h want 100", mem_rd_addr); end
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL f_early: got %b want 0", if_rvalid); end
    nxt(); #1;
    total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL f_rvalid: got %b want 1", if_rvalid); end
    total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL f_rdata: got %h want deadbeef", if_rdata); end
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL f_drv: got %b want 0", d_rvalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL f_idle: got %b want 0", busy); end
    nxt(); #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL f_pulse: got %b want 0", if_rvalid); end
    total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL f_hold: got %h want deadbeef", if_rdata); end
  endtask

  task automatic test_store();
    nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h11223344; #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL s_gnt: got %b want 1", d_gnt); end
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL s_we0: got %b want 0", mem_wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL s_busy0: got %b want 0", busy); end
    nxt(); d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; #1;
    total++; if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL s_we1: got %b want 1", mem_wr_en); end
    total++; if (mem_wr_addr !== 32'h40) begin bad++; $display("FAIL s_addr: got %h want 40", mem_wr_addr); end
    total++; if (mem_wr_data !== 32'h11223344) begin bad++; $display("FAIL s_data: got %h want 11223344", mem_wr_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL s_busy1: got %b want 1", busy); end
    nxt(); #1;
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL s_we2: got %b want 0", mem_wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL s_busy2: got %b want 0", busy); end
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL s_rv: got %b want 00", {if_rvalid, d_rvalid}); end
    total++; if (mem_wr_addr !== 32'h40) begin bad++; $display("FAIL s_hold: got %h want 40", mem_wr_addr); end
  endtask

  task automatic test_back_to_back();
    bit expf[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int n = 0;
    int last = 0;
    nxt(); if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; #1;
    for (int c = 0; c < 40 && n < 10; c++) begin
      if (c > 0) begin nxt(); #1; end
      total++; if ((if_gnt & d_gnt) !== 1'b0) begin bad++; $display("FAIL b_two: got %b%b want one-hot", if_gnt, d_gnt); end
      if (if_gnt | d_gnt) begin
        total++; if (if_gnt !== expf[n]) begin bad++; $display("FAIL b_who%0d: got fetch=%b want %b", n, if_gnt, expf[n]); end
        if (n > 0) begin
          total++; if (c - last != 3) begin bad++; $display("FAIL b_gap%0d: got %0d want 3", n, c - last); end
        end
        last = c;
        n++;
      end
    end
    total++; if (n != 10) begin bad++; $display("FAIL b_count: got %0d want 10", n); end
    nxt(); if_req = 1'b0; d_req = 1'b0; d_addr = 32'h0; if_addr = 32'h0;
    repeat (3) nxt();
  endtask

  task automatic test_load_then_fetch();
    int g;
    nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'h200; #1;
    g = cyc; data_cyc = g + 2; data_val = 32'hCAFEF00D;
    total++; if ({if_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL l_gnt: got %b want 01", {if_gnt, d_gnt}); end
    nxt(); d_req = 1'b0; d_addr = 32'h0; #1;
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL l_wait1: got %b want 0", if_gnt); end
    total++; if (mem_rd_addr !== 32'h80) begin bad++; $display("FAIL l_addr: got %h want 80", mem_rd_addr); end
    nxt(); #1;
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL l_wait2: got %b want 0", if_gnt); end
    nxt(); #1;
    data_cyc = g + 5; data_val = 32'h12345678;
    total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL l_drv: got %b want 1", d_rvalid); end
    total++; if (d_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL l_drd: got %h want cafef00d", d_rdata); end
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL l_irv: got %b want 0", if_rvalid); end
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL l_fgnt: got %b want 1", if_gnt); end
    nxt(); if_req = 1'b0; if_addr = 32'h0; #1;
    total++; if (mem_rd_addr !== 32'h200) begin bad++; $display("FAIL l_faddr: got %h want 200", mem_rd_addr); end
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL l_dpulse: got %b want 0", d_rvalid); end
    nxt(); nxt(); #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b10) begin bad++; $display("FAIL l_frv: got %b want 10", {if_rvalid, d_rvalid}); end
    total++; if (if_rdata !== 32'h12345678) begin bad++; $display("FAIL l_frd: got %h want 12345678", if_rdata); end
    total++; if (d_rdata !== 32'h12345678) begin bad++; $display("FAIL l_shared: got %h want 12345678", d_rdata); end
  endtask

  task automatic test_reset_abort();
    int g;
    nxt(); if_req = 1'b1; if_addr = 32'h900; #1;
    g = cyc; data_cyc = g + 2; data_val = 32'h55AA55AA;
    nxt(); if_req = 1'b0; if_addr = 32'h0; #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL r_busy: got %b want 1", busy); end
    #1; reset_i = 1'b1; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL r_async: got %b want 0", busy); end
    total++; if ((mem_rd_addr | if_rdata) !== 32'h0) begin bad++; $display("FAIL r_regs: got %h want 0", mem_rd_addr | if_rdata); end
    nxt(); nxt(); reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({if_rvalid, d_rvalid, busy} !== 3'b000) begin bad++; $display("FAIL r_quiet%0d: got %b want 000", i, {if_rvalid, d_rvalid, busy}); end
      nxt();
    end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hA1A1A1A1; #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL r_sgnt: got %b want 1", d_gnt); end
    nxt(); d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; #1;
    total++; if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL r_we: got %b want 1", mem_wr_en); end
    #1; reset_i = 1'b1; #1;
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL r_wedrop: got %b want 0", mem_wr_en); end
    total++; if ((mem_wr_addr | mem_wr_data) !== 32'h0) begin bad++; $display("FAIL r_wregs: got %h want 0", mem_wr_addr | mem_wr_data); end
    nxt(); reset_i = 1'b0; #1;
    total++; if ({mem_wr_en, busy} !== 2'b00) begin bad++; $display("FAIL r_wpost: got %b want 00", {mem_wr_en, busy}); end
    nxt(); if_req = 1'b1; if_addr = 32'h300; #1;
    g = cyc; data_cyc = g + 2; data_val = 32'h13579BDF;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL r_ngnt: got %b want 1", if_gnt); end
    nxt(); if_req = 1'b0; if_addr = 32'h0;
    nxt(); nxt(); #1;
    total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL r_nrv: got %b want 1", if_rvalid); end
    total++; if (if_rdata !== 32'h13579BDF) begin bad++; $display("FAIL r_nrd: got %h want 13579bdf", if_rdata); end
  endtask

  task automatic test_lat_sweep();
    int g;
    logic e;
    nxt(); s_req = 1'b1; s_addr = 32'h500; #1;
    g = cyc;
    s_dcyc[0] = g + 1; s_dval[0] = 32'h0000AAAA;
    s_dcyc[1] = g + 8; s_dval[1] = 32'h77770007;
    total++; if (s_gnt !== 2'b11) begin bad++; $display("FAIL w_gnt: got %b want 11", s_gnt); end
    for (int i = 1; i <= 11; i++) begin
      nxt();
      if (i == 1) begin s_req = 1'b0; s_addr = 32'h0; end
      #1;
      for (int k = 0; k < 2; k++) begin
        e = (i == 2 + s_lat[k]);
        total++; if (s_rv[k] !== e) begin bad++; $display("FAIL w_rv_lat%0d_t%0d: got %b want %b", s_lat[k], i, s_rv[k], e); end
        if (e) begin
          total++; if (s_rdata[k] !== s_dval[k]) begin bad++; $display("FAIL w_rd_lat%0d: got %h want %h", s_lat[k], s_rdata[k], s_dval[k]); end
        end
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    s_req = 1'b0; s_addr = '0;
    test_reset();
    test_fetch_only();
    test_store();
    test_back_to_back();
    test_load_then_fetch();
    test_reset_abort();
    test_lat_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
